// File: rtl/spi_controller_pkg.sv
// ---------------------------------------------------------------------------
// spi_controller_pkg
//   Shared definitions for the SPI controller slice:
//     state_e          - controller FSM states
//     MODE_0..MODE_3   - SPI mode indices, mode = {cpol, cpha}
//     mode_cpol/cpha   - decode a mode index back into its polarity/phase bits
// ---------------------------------------------------------------------------
package spi_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return (mode == MODE_2) || (mode == MODE_3);
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return (mode == MODE_1) || (mode == MODE_3);
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// ---------------------------------------------------------------------------
// spi_controller_if
//   Bundles the request/response handshake and the SPI bus pins.
//   Inputs to the controller : ena, start, tx_data, cpol, cpha, miso
//   Outputs of the controller: sclk, mosi, cs_n, rx_data, busy, done
//   Modports:
//     slave  - the controller side (spi_controller)
//     master - the requesting side (host logic / testbench)
// ---------------------------------------------------------------------------
interface spi_controller_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             cpol;
  logic             cpha;
  logic             miso;
  logic             sclk;
  logic             mosi;
  logic             cs_n;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;

  modport slave (
    input  ena, start, tx_data, cpol, cpha, miso,
    output sclk, mosi, cs_n, rx_data, busy, done
  );

  modport master (
    output ena, start, tx_data, cpol, cpha, miso,
    input  sclk, mosi, cs_n, rx_data, busy, done
  );
endinterface

// File: rtl/spi_controller_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
//   Half-period divider and sclk toggle counter for spi_controller.
//   Ports:
//     clk, rstb  - clock, synchronous active-low reset
//     ena        - global enable; counters hold while low
//     cnt_en     - controller is in a non-idle state; counters clear when low
//     edge_en    - controller is in SETUP or TRANSFER; toggles allowed
//     tick       - divider reached the end of a half-period (one cycle)
//     lead/trail - the register update at this edge is a leading/trailing toggle
//     last_edge  - this strobe is the final (2*WIDTH-th) toggle
// ---------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic cnt_en,
  input  logic edge_en,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic last_edge
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_NUM  = EDGE_W'(2 * WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              fire;

  // edge_q counts toggles already issued; a strobe announces toggle edge_q+1,
  // which is a leading edge when edge_q is even. Once 2*WIDTH toggles are out
  // the counter parks there, so it can never wrap inside a transaction.
  always_comb begin
    tick      = ena && cnt_en && (div_q == DIV_MAX);
    fire      = tick && edge_en && (edge_q != EDGE_NUM);
    lead      = fire && !edge_q[0];
    trail     = fire && edge_q[0];
    last_edge = fire && (edge_q == EDGE_LAST);
    div_d     = div_q;
    edge_d    = edge_q;
    if (!cnt_en) begin
      div_d  = '0;
      edge_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (fire) edge_d = edge_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      div_q  <= '0;
      edge_q <= '0;
    end else if (ena) begin
      div_q  <= div_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//   Single-word SPI master supporting all four modes, WIDTH bits per word,
//   sclk half-period of CLK_DIV clk cycles. All bus outputs are registered.
//   Ports:
//     clk   - system clock (rising edge)
//     rstb  - synchronous active-low reset
//     bus   - spi_controller_if.slave: ena, start, tx_data, cpol, cpha, miso
//             in; sclk, mosi, cs_n, rx_data, busy, done out
//   Configuration macro:
//     SPI_CONTROLLER_LSB_FIRST_EN - shift mosi and assemble rx_data LSB first
//                                   (default MSB first); timing unchanged.
// ---------------------------------------------------------------------------
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rstb,
  spi_controller_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_en, edge_en;
  logic             tick, lead, trail, last_edge;
  logic             cpha;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w,
                                                input logic b);
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    return {b, w[WIDTH-1:1]};
`else
    return {w[WIDTH-2:0], b};
`endif
  endfunction

  assign cnt_en  = (state_q != IDLE);
  assign edge_en = (state_q == SETUP) || (state_q == TRANSFER);

  spi_sclk_gen #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (bus.ena),
    .cnt_en    (cnt_en),
    .edge_en   (edge_en),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    cpha      = mode_cpha(mode_q);

    case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        mosi_d = 1'b0;
        // done_q marks the return cycle; a start seen there waits one cycle.
        if (bus.start && !done_q) begin
          state_d = SETUP;
          mode_d  = {bus.cpol, bus.cpha};
          if (bus.cpha) begin
            tx_sh_d = bus.tx_data;
          end else begin
            // cpha=0 presents the first bit for the whole SETUP half-period.
            mosi_d  = first_bit(bus.tx_data);
            tx_sh_d = shift_out(bus.tx_data);
          end
        end
      end
      SETUP: begin
        sclk_d = mode_cpol(mode_q);
        if (tick) state_d = TRANSFER;
      end
      TRANSFER: begin
        // A tick with no toggle left means all 2*WIDTH edges are out.
        if (tick && !(lead || trail)) state_d = HOLD;
      end
      HOLD: begin
        sclk_d = mode_cpol(mode_q);
        if (tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lead || trail) sclk_d = ~sclk_q;

    // Shift-out edge depends on phase; cpha=0 skips the final trailing edge
    // because its first bit was already presented at SETUP entry.
    if (cpha ? lead : (trail && !last_edge)) begin
      mosi_d  = first_bit(tx_sh_q);
      tx_sh_d = shift_out(tx_sh_q);
    end

    if (cpha ? trail : lead) rx_sh_d = shift_in(rx_sh_q, bus.miso);

    cs_n_d = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else if (bus.ena) begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Shift registers and latched mode carry data only; they are reloaded on
  // every accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    if (bus.ena) begin
      mode_q  <= mode_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
//   Directed bench for spi_controller. dut runs at CLK_DIV=4 against an SPI
//   peripheral model; dut_b runs at CLK_DIV=1 with start held high.
//   Honours SPI_CONTROLLER_LSB_FIRST_EN for bit order in the peripheral.
// ---------------------------------------------------------------------------
module tb_spi_controller;
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  spi_controller_if #(.WIDTH(8)) bus ();
  spi_controller_if #(.WIDTH(8)) bus_b ();

  spi_controller #(.WIDTH(8), .CLK_DIV(4)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  spi_controller #(.WIDTH(8), .CLK_DIV(1)) dut_b (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Peripheral model state
  logic       loop;
  logic       miso_r;
  logic [7:0] p_tx;
  logic [7:0] p_rx;
  logic       p_first;
  logic       p_cpol, p_cpha;
  int         p_idx = 0;
  logic       cs_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  assign bus.miso   = loop ? bus.mosi : miso_r;
  assign bus_b.miso = 1'b0;

  function automatic int ord(input int i);
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  // Peripheral: drives miso on the edge opposite to the controller's sample
  // edge and captures mosi on the controller's sample edge.
  always @(negedge clk) begin
    if (bus.cs_n !== 1'b0) begin
      miso_r = p_tx[ord(0)];
    end else if (cs_prev === 1'b1) begin
      p_idx = 0;
      p_rx  = 8'h00;
    end else if (bus.sclk !== sclk_prev) begin
      if (bus.sclk !== p_cpol) begin
        if (p_cpha) begin
          miso_r = p_tx[ord(p_idx)];
        end else begin
          p_rx[ord(p_idx)] = bus.mosi;
          if (p_idx == 0) p_first = bus.mosi;
          p_idx++;
        end
      end else begin
        if (p_cpha) begin
          p_rx[ord(p_idx)] = bus.mosi;
          if (p_idx == 0) p_first = bus.mosi;
          p_idx++;
        end else if (p_idx < 8) begin
          miso_r = p_tx[ord(p_idx)];
        end
      end
    end
    cs_prev   = bus.cs_n;
    sclk_prev = bus.sclk;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic pol, input logic pha,
                          input int ena_at, input int ena_len,
                          output int low, output int dones, output logic [7:0] rx,
                          output logic done_ok, output logic sb, output logic sa);
    bus.tx_data = tx;
    bus.cpol    = pol;
    bus.cpha    = pha;
    p_cpol      = pol;
    p_cpha      = pha;
    cyc(2);
    sb = bus.sclk;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    low = 0;
    dones = 0;
    done_ok = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (i == ena_at) bus.ena = 1'b0;
      if (i == ena_at + ena_len) bus.ena = 1'b1;
      if (bus.cs_n === 1'b0) low++;
      if (bus.done === 1'b1) begin
        dones++;
        if (!(bus.cs_n === 1'b1 && bus.busy === 1'b0)) done_ok = 1'b0;
      end
      cyc(1);
    end
    bus.ena = 1'b1;
    rx = bus.rx_data;
    sa = bus.sclk;
  endtask

  int b_dones = 0;
  int b_busy_bad = 0;

  task automatic measure_b(input logic lvl, output int len);
    len = 0;
    while (bus_b.cs_n === lvl && len < 200) begin
      if (bus_b.done === 1'b1) b_dones++;
      if (bus_b.busy !== ~lvl) b_busy_bad++;
      len++;
      cyc(1);
    end
  endtask

  initial begin
    int         low, dones, dcount, l1, h1, l2, h2;
    logic [7:0] rx, tx;
    logic       dok, sb, sa;

    rstb = 1'b0;
    bus.ena = 1'b1;   bus.start = 1'b0;   bus.tx_data = 8'h00;
    bus.cpol = 1'b1;  bus.cpha = 1'b0;
    bus_b.ena = 1'b1; bus_b.start = 1'b0; bus_b.tx_data = 8'h96;
    bus_b.cpol = 1'b0; bus_b.cpha = 1'b0;
    loop = 1'b0; p_tx = 8'h00; p_cpol = 1'b0; p_cpha = 1'b0; p_first = 1'b0;
    cyc(3);

    // Reset state (cpol input high, sclk must still be forced low)
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rx", bus.rx_data, 0);
    chk("rst_b_cs_n", bus_b.cs_n, 1);

    // Idle: sclk follows cpol with one-cycle latency, mosi low
    rstb = 1'b1;
    cyc(1);
    chk("idle_sclk_hi", bus.sclk, 1);
    bus.cpol = 1'b0;
    cyc(1);
    chk("idle_sclk_lo", bus.sclk, 0);
    chk("idle_mosi", bus.mosi, 0);

    // ena low: start not accepted
    bus.ena = 1'b0; bus.start = 1'b1;
    cyc(3);
    chk("ena_low_cs_n", bus.cs_n, 1);
    bus.start = 1'b0; bus.ena = 1'b1;
    cyc(1);

    // Mode 0 loopback 0xA5
    loop = 1'b1;
    run_xfer(8'hA5, 1'b0, 1'b0, -1, 0, low, dones, rx, dok, sb, sa);
    loop = 1'b0;
    chk("m0_cs_low", low, 72);
    chk("m0_dones", dones, 1);
    chk("m0_done_cyc", dok, 1);
    chk("m0_rx", rx, 8'hA5);
    chk("m0_mosi_bits", p_rx, 8'hA5);

    // Modes 1..3, tx 0x3C, peripheral sends 0xC3
    p_tx = 8'hC3;
    for (int m = 1; m < 4; m++) begin
      run_xfer(8'h3C, m[1], m[0], -1, 0, low, dones, rx, dok, sb, sa);
      chk($sformatf("m%0d_rx", m), rx, 8'hC3);
      chk($sformatf("m%0d_mosi", m), p_rx, 8'h3C);
      chk($sformatf("m%0d_cs_low", m), low, 72);
      chk($sformatf("m%0d_dones", m), dones, 1);
      chk($sformatf("m%0d_sclk_before", m), sb, m[1]);
      chk($sformatf("m%0d_sclk_after", m), sa, m[1]);
    end

    // ena dropped for 5 cycles mid-transfer
    p_tx = 8'h5A;
    run_xfer(8'h96, 1'b0, 1'b0, 30, 5, low, dones, rx, dok, sb, sa);
    chk("ena_cs_low", low, 77);
    chk("ena_rx", rx, 8'h5A);
    chk("ena_mosi", p_rx, 8'h96);
    chk("ena_dones", dones, 1);

    // Reset at cycle 20 of a mode-3 transfer
    p_tx = 8'hC3;
    bus.tx_data = 8'h5A; bus.cpol = 1'b1; bus.cpha = 1'b1;
    p_cpol = 1'b1; p_cpha = 1'b1;
    cyc(2);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(19);
    chk("pre_rst_busy", bus.busy, 1);
    rstb = 1'b0;
    cyc(1);
    chk("abort_cs_n", bus.cs_n, 1);
    chk("abort_sclk", bus.sclk, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_rx", bus.rx_data, 0);
    rstb = 1'b1;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (bus.done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_xfer(8'h3C, 1'b1, 1'b1, -1, 0, low, dones, rx, dok, sb, sa);
    chk("post_rst_rx", rx, 8'hC3);
    chk("post_rst_mosi", p_rx, 8'h3C);
    chk("post_rst_cs_low", low, 72);

    // Bit order: first mosi bit is 1 and the word round-trips
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    tx = 8'h01;
`else
    tx = 8'h80;
`endif
    p_tx = tx;
    run_xfer(tx, 1'b0, 1'b0, -1, 0, low, dones, rx, dok, sb, sa);
    chk("order_first_bit", p_first, 1);
    chk("order_rx", rx, tx);
    chk("order_mosi", p_rx, tx);

    // CLK_DIV=1, start held high: back-to-back with two-cycle gaps
    bus_b.start = 1'b1;
    for (int i = 0; i < 10 && bus_b.cs_n !== 1'b0; i++) cyc(1);
    measure_b(1'b0, l1);
    measure_b(1'b1, h1);
    measure_b(1'b0, l2);
    measure_b(1'b1, h2);
    bus_b.start = 1'b0;
    cyc(25);
    chk("b2b_low1", l1, 18);
    chk("b2b_gap1", h1, 2);
    chk("b2b_low2", l2, 18);
    chk("b2b_gap2", h2, 2);
    chk("b2b_dones", b_dones, 2);
    chk("b2b_busy", b_busy_bad, 0);
    chk("b2b_idle_cs_n", bus_b.cs_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
